// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the seven-segment scan driver.
// Glyphs are active-high, bit0=a .. bit6=g.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;

  localparam seg_t GLYPH_0 = 7'b0111111;
  localparam seg_t GLYPH_1 = 7'b0000110;
  localparam seg_t GLYPH_2 = 7'b1011011;
  localparam seg_t GLYPH_3 = 7'b1001111;
  localparam seg_t GLYPH_4 = 7'b1100110;
  localparam seg_t GLYPH_5 = 7'b1101101;
  localparam seg_t GLYPH_6 = 7'b1111101;
  localparam seg_t GLYPH_7 = 7'b0000111;
  localparam seg_t GLYPH_8 = 7'b1111111;
  localparam seg_t GLYPH_9 = 7'b1101111;
  localparam seg_t GLYPH_A = 7'b1110111;
  localparam seg_t GLYPH_B = 7'b1111100;
  localparam seg_t GLYPH_C = 7'b0111001;
  localparam seg_t GLYPH_D = 7'b1011110;
  localparam seg_t GLYPH_E = 7'b1111001;
  localparam seg_t GLYPH_F = 7'b1110001;

endpackage

// File: rtl/seg7_glyph.sv
// Nibble to active-high segment pattern.
// Codes above 9 fall back to blank unless hex glyphs are enabled.
import seg7_pkg::*;

module seg7_glyph (
  input  logic [3:0] nib,
  input  logic       hex_mode,
  output seg_t       seg
);

  // Table lookup; hex letters gated by hex_mode
  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = hex_mode ? GLYPH_A : SEG_BLANK;
      4'hB: seg = hex_mode ? GLYPH_B : SEG_BLANK;
      4'hC: seg = hex_mode ? GLYPH_C : SEG_BLANK;
      4'hD: seg = hex_mode ? GLYPH_D : SEG_BLANK;
      4'hE: seg = hex_mode ? GLYPH_E : SEG_BLANK;
      4'hF: seg = hex_mode ? GLYPH_F : SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multi-digit time-multiplexed seven-segment driver.
// Shadowed value/dp, leading-zero blanking, registered outputs.
import seg7_pkg::*;

module seg7_scan_driver #(
  parameter int NDIGITS    = 8,
  parameter int SCAN_DIV   = 1000,
  parameter int HEX_MODE   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic                   blank_lz,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame_tick
);

  localparam int IW = $clog2(NDIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] I_MAX = IW'(NDIGITS - 1);
  localparam logic [PW-1:0] P_MAX = PW'(SCAN_DIV - 1);
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic HEX = (HEX_MODE != 0);

  logic [4*NDIGITS-1:0] shadow_val;
  logic [NDIGITS-1:0]   shadow_dp;
  logic [PW-1:0]        presc;
  logic [IW-1:0]        idx;
  logic                 wrap;
  logic [3:0]           digit [NDIGITS];
  logic [NDIGITS-1:0]   lz;
  logic [NDIGITS-1:0]   an_d;
  logic                 all_zero;
  seg_t                 glyph;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
    assign digit[g] = shadow_val[4*g +: 4];
  end

  assign wrap = en && (presc == P_MAX);

  // Shadow registers: load works regardless of en
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp_in;
    end
  end

  // Prescaler, digit index and end-of-frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap && (idx == I_MAX);
      if (en) begin
        if (wrap) begin
          presc <= '0;
          idx   <= (idx == I_MAX) ? '0 : idx + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  // Leading-zero mask: digit i blank when it and all above are zero
  always_comb begin
    lz       = '0;
    all_zero = 1'b1;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (digit[i] == 4'h0);
      lz[i]    = blank_lz && all_zero;
    end
  end

  // One-hot digit select for the current index
  always_comb begin
    an_d      = '0;
    an_d[idx] = 1'b1;
  end

  seg7_glyph u_glyph (
    .nib      (digit[idx]),
    .hex_mode (HEX),
    .seg      (glyph)
  );

  // Output register with polarity applied; inactive when disabled
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      seg <= {7{POL}};
      dp  <= POL;
      an  <= {NDIGITS{POL}};
    end else begin
      seg <= (lz[idx] ? SEG_BLANK : glyph) ^ {7{POL}};
      dp  <= shadow_dp[idx] ^ POL;
      an  <= an_d ^ {NDIGITS{POL}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver, 4 digits, 4-clock scan.
// Two instances differ only in HEX_MODE.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst, en, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg1, seg0;
  logic        dp1, dp0, ft1, ft0;
  logic [3:0]  an1, an0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NDIGITS(4), .SCAN_DIV(4), .HEX_MODE(1), .ACTIVE_LOW(1)
  ) dut_hex (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg1), .dp(dp1),
    .an(an1), .frame_tick(ft1)
  );

  seg7_scan_driver #(
    .NDIGITS(4), .SCAN_DIV(4), .HEX_MODE(0), .ACTIVE_LOW(1)
  ) dut_dec (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg0), .dp(dp0),
    .an(an0), .frame_tick(ft0)
  );

  typedef struct {
    logic [6:0] seg1;
    logic [6:0] seg0;
    logic       dp;
    logic [3:0] an;
    logic       ft;
  } exp_t;

  exp_t q[$];

  logic [15:0] m_val;
  logic [3:0]  m_dp;
  int          m_presc;
  int          m_idx;

  function automatic logic [6:0] ref_glyph(logic [3:0] n, bit hex);
    logic [6:0] t [16];
    t = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
          7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
          7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
          7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
    if (n > 4'd9 && !hex) return 7'b0000000;
    return t[n];
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    logic [3:0] d;
    bit blank;
    if (rst || !en) begin
      e.seg1 = 7'h7F;
      e.seg0 = 7'h7F;
      e.dp   = 1'b1;
      e.an   = 4'hF;
    end else begin
      d     = m_val[4*m_idx +: 4];
      blank = blank_lz && (m_idx >= 1) && ((m_val >> (4*m_idx)) == 16'h0);
      e.seg1 = blank ? 7'h7F : ~ref_glyph(d, 1'b1);
      e.seg0 = blank ? 7'h7F : ~ref_glyph(d, 1'b0);
      e.dp   = ~m_dp[m_idx];
      e.an   = ~(4'b0001 << m_idx);
    end
    e.ft = !rst && en && (m_presc == 3) && (m_idx == 3);
    q.push_back(e);
    if (rst) begin
      m_val = '0; m_dp = '0; m_presc = 0; m_idx = 0;
    end else begin
      if (load) begin
        m_val = value;
        m_dp  = dp_in;
      end
      if (en) begin
        if (m_presc == 3) begin
          m_presc = 0;
          m_idx   = (m_idx + 1) % 4;
        end else begin
          m_presc++;
        end
      end
    end
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("sb_seg_hex", {9'b0, seg1}, {9'b0, e.seg1});
    chk("sb_seg_dec", {9'b0, seg0}, {9'b0, e.seg0});
    chk("sb_dp",      {15'b0, dp1}, {15'b0, e.dp});
    chk("sb_dp_dec",  {15'b0, dp0}, {15'b0, e.dp});
    chk("sb_an",      {12'b0, an1}, {12'b0, e.an});
    chk("sb_an_dec",  {12'b0, an0}, {12'b0, e.an});
    chk("sb_ft",      {15'b0, ft1}, {15'b0, e.ft});
    chk("sb_ft_dec",  {15'b0, ft0}, {15'b0, e.ft});
  endtask

  task automatic goto(int i, int p);
    int n = 0;
    while (!(m_idx == i && m_presc == p) && n < 64) begin
      step();
      n++;
    end
    chk("goto_bound", 16'(n >= 64), 16'h0);
  endtask

  initial begin
    int nft = 0;
    m_val = '0; m_dp = '0; m_presc = 0; m_idx = 0;
    rst = 1'b1; en = 1'b0; load = 1'b0; blank_lz = 1'b0;
    value = '0; dp_in = '0;

    step();
    step();
    chk("rst_an",  {12'b0, an1}, 16'h000F);
    chk("rst_seg", {9'b0, seg1}, 16'h007F);
    chk("rst_dp",  {15'b0, dp1}, 16'h0001);
    chk("rst_ft",  {15'b0, ft1}, 16'h0000);

    rst = 1'b0; en = 1'b1; load = 1'b1; value = 16'h1234;
    step();
    load = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (ft1) nft++;
      if (k == 1) begin
        chk("scan_an0",  {12'b0, an1}, 16'h000E);
        chk("scan_seg0", {9'b0, seg1}, 16'h0019);
      end
      if (k == 4) begin
        chk("scan_an1",  {12'b0, an1}, 16'h000D);
        chk("scan_seg1", {9'b0, seg1}, 16'h0030);
      end
      if (k == 8) begin
        chk("scan_an2",  {12'b0, an1}, 16'h000B);
        chk("scan_seg2", {9'b0, seg1}, 16'h0024);
      end
      if (k == 12) begin
        chk("scan_an3",  {12'b0, an1}, 16'h0007);
        chk("scan_seg3", {9'b0, seg1}, 16'h0079);
      end
    end
    chk("frame_cnt", 16'(nft), 16'd2);

    blank_lz = 1'b1; load = 1'b1; value = 16'h00A0;
    step();
    load = 1'b0;
    goto(1, 0);
    step();
    chk("hexA",   {9'b0, seg1}, 16'h0008);
    chk("decA",   {9'b0, seg0}, 16'h007F);
    goto(0, 0);
    step();
    chk("lz_d0",  {9'b0, seg1}, 16'h0040);
    goto(2, 0);
    step();
    chk("lz_d2",  {9'b0, seg0}, 16'h007F);
    chk("lz_an2", {12'b0, an0}, 16'h000B);

    load = 1'b1; value = 16'h0000; dp_in = 4'b0100;
    step();
    load = 1'b0;
    goto(2, 0);
    step();
    chk("dp_seg2", {9'b0, seg1}, 16'h007F);
    chk("dp_on2",  {15'b0, dp1}, 16'h0000);
    goto(0, 0);
    step();
    chk("z_seg0", {9'b0, seg1}, 16'h0040);
    chk("z_dp0",  {15'b0, dp1}, 16'h0001);

    dp_in = 4'b0000;
    goto(1, 2);
    load = 1'b1; value = 16'h0050;
    step();
    load = 1'b0;
    step();
    chk("mid_seg", {9'b0, seg1}, 16'h0012);
    chk("mid_an",  {12'b0, an1}, 16'h000D);
    step();
    chk("mid_adv", {12'b0, an1}, 16'h000B);

    goto(2, 1);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) begin
        chk("off_an",  {12'b0, an1}, 16'h000F);
        chk("off_seg", {9'b0, seg1}, 16'h007F);
      end
    end
    en = 1'b1;
    step();
    step();
    step();
    chk("resume_an2", {12'b0, an1}, 16'h000B);
    step();
    chk("resume_an3", {12'b0, an1}, 16'h0007);

    goto(2, 2);
    rst = 1'b1; load = 1'b1; value = 16'hFFFF;
    step();
    chk("rl_an",  {12'b0, an1}, 16'h000F);
    chk("rl_seg", {9'b0, seg1}, 16'h007F);
    rst = 1'b0; load = 1'b0; blank_lz = 1'b0;
    step();
    chk("rl_an0",  {12'b0, an1}, 16'h000E);
    chk("rl_seg0", {9'b0, seg1}, 16'h0040);
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
